pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle control FSM that sequences the program counter and instruction fetch for the RISC-V core. It drives the 4-bit `pc_control` bundle {reset, enable, pc_src, jalr} consumed by `program_counter`, handshakes with instruction and data memory, resolves branches from ALU compare flags, and counts retired instructions. It sits between the memories, the ALU compare outputs and the PC/register-file write enables.

## Interface
- `RETIRE_W`, 32: width of retired-instruction counter.
- `HALT_ON_ILLEGAL`, 1: 1 = unrecognised opcode halts; 0 = treated as NOP.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request, held until ack.
- `imem_ack`  in  1  instruction valid on `instr` this cycle.
- `instr`  in  32  instruction word from memory.
- `dmem_req`  out  1  load/store request, held until ack.
- `dmem_ack`  in  1  data access complete.
- `br_eq`, `br_lt`, `br_ltu`  in  1 each  rs1-vs-rs2 compare flags from ALU.
- `pc_control`  out  4  {[3] reset, [2] enable, [1] pc_src, [0] jalr} to PC.
- `ir`  out  32  latched instruction register.
- `reg_we`  out  1  register-file write strobe.
- `halted`  out  1  sticky halt flag.
- `retired`  out  RETIRE_W  retired-instruction count.

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, UPDATE, HALT.
- BOOT: `pc_control=4'b1000`; always exits to FETCH after one cycle.
- FETCH: `imem_req=1`; on `imem_ack` latch `instr` into `ir` and go to DECODE; otherwise stay.
- DECODE: classify `ir[6:0]`. SYSTEM (1110011) goes to HALT. Unknown opcode goes to HALT if HALT_ON_ILLEGAL, else is treated as NOP. All other opcodes go to EXEC.
- EXEC: register `taken` from the branch decision. LOAD (0000011) and STORE (0100011) go to MEM; others go to UPDATE.
- Branch decision by funct3:
  - 000 br_eq; 001 !br_eq; 100 br_lt; 101 !br_lt; 110 br_ltu; 111 !br_ltu.
  - 010 and 011 give not-taken.
- MEM: `dmem_req=1` until `dmem_ack`, then go to UPDATE.
- UPDATE: `pc_control[2]=1` for exactly one cycle; `retired` increments by 1; then go to FETCH.
- UPDATE, next-PC select:
  - JAL (1101111): pc_src=1, jalr=0.
  - JALR (1100111): pc_src=0, jalr=1.
  - BRANCH (1100011): pc_src=taken, jalr=0.
  - Else 00.
- UPDATE, `reg_we=1` for LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD. `reg_we=0` for STORE, BRANCH, and NOP-treated illegal opcodes.
- HALT: `halted=1`, all requests and strobes 0, `pc_control=4'b0000`. PC is frozen at the halting instruction. Only reset exits.
- `retired` wraps modulo 2^RETIRE_W.

## Timing
- Values while `rst_n` is low (state BOOT):
  - `pc_control=4'b1000`; PC clears on every clock edge during reset.
  - `imem_req=dmem_req=reg_we=halted=0`, `ir=0`, `retired=0`.
- BOOT lasts exactly one cycle after `rst_n` rises.
- Outputs are Moore-decoded from registered state; only `ir`, `taken` and `retired` are additional registers.
- `imem_ack` is accepted in the first FETCH cycle (zero wait), so ack may be high on the cycle `imem_req` rises.
- Minimum latency per instruction: 4 cycles (FETCH, DECODE, EXEC, UPDATE); loads/stores take 5. Each wait cycle adds 1.
- PC changes on the clock edge ending UPDATE. `ir` holds from FETCH ack until the next FETCH ack.
- Compare flags are sampled only in EXEC and ignored elsewhere. They must be valid in EXEC for the rs1/rs2 of `ir`.
- `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored. A stray ack must not advance the FSM.
- `rst_n` asserted in any state, including mid-wait in FETCH/MEM, forces BOOT immediately. Requests drop asynchronously, and the pending access is abandoned.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - state enum `seq_state_t`;
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_SYSTEM);
  - `pc_control` bit indices PCC_RESET=3, PCC_EN=2, PCC_SRC=1, PCC_JALR=0.
- Sub-module `branch_resolve`: combinational; inputs funct3 and the three flags, output taken. It is reused by the ALU/branch unit.

## Test plan
- Reset then ADDI with zero-wait ack: `pc_control=1000` during reset and BOOT. Enable pulses in cycle 4 after FETCH entry with `pc_control=0100`; `reg_we=1`; `retired=1`.
- BEQ, br_eq=1: UPDATE drives `0110`, `reg_we=0`. Same instruction with br_eq=0 drives `0100`.
- All six funct3 values against all flag combinations match the truth table. funct3=010 with flags=1 is not taken.
- JAL gives `0110` and JALR gives `0101`, both with `reg_we=1`. LW with `dmem_ack` delayed 3 cycles keeps `dmem_req` high 4 cycles, and the enable pulse comes 8 cycles after FETCH entry.
- ECALL: `halted=1`, enable never pulses, `retired` is unchanged, and stray `imem_ack` is ignored. `rst_n` low mid-FETCH wait returns to BOOT and clears `ir` and `retired`.
- Preload `retired=2^32-1` via a 32-bit hierarchical force, then retire 1 instruction: `retired=0`.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: sequencer states, RV32I major opcodes, pc_control bit map.
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    UPDATE = 3'd5,
    HALT   = 3'd6
  } seq_state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int PCC_RESET = 3;
  localparam int PCC_EN    = 2;
  localparam int PCC_SRC   = 1;
  localparam int PCC_JALR  = 0;

  function automatic logic is_known_op(input logic [6:0] op);
    logic known;
    known = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_SYSTEM: known = 1'b1;
      default:                                     known = 1'b0;
    endcase
    return known;
  endfunction

  function automatic logic op_writes_rd(input logic [6:0] op);
    logic wr;
    wr = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP, OP_LOAD: wr = 1'b1;
      default:                                                   wr = 1'b0;
    endcase
    return wr;
  endfunction

  function automatic logic op_is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve.sv
// Conditional-branch decision from funct3 and the ALU rs1/rs2 compare flags.
`default_nettype none

module branch_resolve (
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = br_eq;
      3'b001:  taken = ~br_eq;
      3'b100:  taken = br_lt;
      3'b101:  taken = ~br_lt;
      3'b110:  taken = br_ltu;
      3'b111:  taken = ~br_ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving PC control, memory handshakes and retire count.
`default_nettype none

module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int RETIRE_W        = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [31:0]         instr,
  output logic                dmem_req,
  input  logic                dmem_ack,
  input  logic                br_eq,
  input  logic                br_lt,
  input  logic                br_ltu,
  output logic [3:0]          pc_control,
  output logic [31:0]         ir,
  output logic                reg_we,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  seq_state_t          state;
  seq_state_t          state_nxt;
  logic [31:0]         ir_q;
  logic                taken_q;
  logic                taken_w;
  logic [RETIRE_W-1:0] retired_q;
  logic [6:0]          opcode;

  assign opcode  = ir_q[6:0];
  assign ir      = ir_q;
  assign retired = retired_q;

  branch_resolve u_branch_resolve (
    .funct3 (ir_q[14:12]),
    .br_eq  (br_eq),
    .br_lt  (br_lt),
    .br_ltu (br_ltu),
    .taken  (taken_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Flags are only meaningful in EXEC, so taken is captured there and held through UPDATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q      <= '0;
      taken_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state == FETCH && imem_ack) begin
        ir_q <= instr;
      end
      if (state == EXEC) begin
        taken_q <= taken_w;
      end
      if (state == UPDATE) begin
        retired_q <= retired_q + RETIRE_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    reg_we     = 1'b0;
    halted     = 1'b0;
    pc_control = 4'b0000;
    case (state)
      BOOT: begin
        pc_control[PCC_RESET] = 1'b1;
        state_nxt             = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_nxt = HALT;
        end else if (HALT_ON_ILLEGAL && !is_known_op(opcode)) begin
          state_nxt = HALT;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = op_is_mem(opcode) ? MEM : UPDATE;
      end
      MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        pc_control[PCC_EN] = 1'b1;
        reg_we             = op_writes_rd(opcode);
        case (opcode)
          OP_JAL:    pc_control[PCC_SRC]  = 1'b1;
          OP_JALR:   pc_control[PCC_JALR] = 1'b1;
          OP_BRANCH: pc_control[PCC_SRC]  = taken_q;
          default:   pc_control[PCC_SRC]  = 1'b0;
        endcase
        state_nxt = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer: per-instruction UPDATE outputs, latency, halt and reset corners.
`timescale 1ns/1ps
`default_nettype none

module tb_pc_sequencer;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        br_eq = 1'b0;
  logic        br_lt = 1'b0;
  logic        br_ltu = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_req;
  logic        dmem_req;
  logic        reg_we;
  logic        halted;
  logic [3:0]  pc_control;
  logic [31:0] ir;
  logic [31:0] retired;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_ret = '0;

  always #5 clk = ~clk;

  pc_sequencer #(.RETIRE_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .dmem_req   (dmem_req),
    .dmem_ack   (dmem_ack),
    .br_eq      (br_eq),
    .br_lt      (br_lt),
    .br_ltu     (br_ltu),
    .pc_control (pc_control),
    .ir         (ir),
    .reg_we     (reg_we),
    .halted     (halted),
    .retired    (retired)
  );

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  flags;   // {br_eq, br_lt, br_ltu}
    int          dwait;
    logic [3:0]  pcc;
    logic        we;
    int          cyc;
    int          dreq;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in the first FETCH cycle; returns in the FETCH cycle after UPDATE.
  task automatic run_instr(input logic [31:0] ins, input logic [2:0] flags, input int dwait,
                           output logic [3:0] pcc, output logic we, output int en_cyc,
                           output int dreq_n, output logic ok);
    int cyc;
    int dcnt;
    bit done;
    pcc = '0; we = 1'b0; en_cyc = -1; dcnt = 0; done = 1'b0; cyc = 1;
    {br_eq, br_lt, br_ltu} = flags;
    instr    = ins;
    imem_ack = 1'b1;
    while (!done && cyc < 40) begin
      if (dmem_req) begin
        dcnt++;
        dmem_ack = (dcnt == dwait + 1);
      end else begin
        dmem_ack = 1'b0;
      end
      if (pc_control[PCC_EN]) begin
        pcc = pc_control; we = reg_we; en_cyc = cyc; done = 1'b1;
      end
      step();
      cyc++;
      imem_ack = 1'b0;
    end
    dmem_ack = 1'b0;
    dreq_n   = dcnt;
    ok       = done;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic halt_seq(input logic [31:0] ins, input string name);
    int en_seen;
    en_seen  = 0;
    instr    = ins;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    chk({name, "_halted"}, {31'b0, halted}, 32'd1);
    chk({name, "_pcc"}, {28'b0, pc_control}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      imem_ack = i[0];
      dmem_ack = ~i[0];
      instr    = 32'h00500093;
      if (pc_control[PCC_EN] || imem_req || dmem_req || reg_we) en_seen++;
      step();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk({name, "_no_activity"}, en_seen, 32'd0);
    chk({name, "_still_halted"}, {31'b0, halted}, 32'd1);
    chk({name, "_retired"}, retired, exp_ret);
    chk({name, "_ir"}, ir, ins);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pcc;
    logic       we;
    logic       ok;
    int         en_cyc;
    int         dreq_n;

    vecs[0]  = '{32'h00500093, 3'b000, 0, 4'b0100, 1'b1, 4, 0};  // ADDI
    vecs[1]  = '{32'h00000463, 3'b100, 0, 4'b0110, 1'b0, 4, 0};  // BEQ taken
    vecs[2]  = '{32'h00000463, 3'b011, 0, 4'b0100, 1'b0, 4, 0};  // BEQ not taken
    vecs[3]  = '{32'h00001463, 3'b000, 0, 4'b0110, 1'b0, 4, 0};  // BNE taken
    vecs[4]  = '{32'h00004463, 3'b010, 0, 4'b0110, 1'b0, 4, 0};  // BLT taken
    vecs[5]  = '{32'h00002463, 3'b111, 0, 4'b0100, 1'b0, 4, 0};  // funct3=010
    vecs[6]  = '{32'h000000EF, 3'b000, 0, 4'b0110, 1'b1, 4, 0};  // JAL
    vecs[7]  = '{32'h000100E7, 3'b000, 0, 4'b0101, 1'b1, 4, 0};  // JALR
    vecs[8]  = '{32'h000010B7, 3'b000, 0, 4'b0100, 1'b1, 4, 0};  // LUI
    vecs[9]  = '{32'h00001097, 3'b000, 0, 4'b0100, 1'b1, 4, 0};  // AUIPC
    vecs[10] = '{32'h002081B3, 3'b000, 0, 4'b0100, 1'b1, 4, 0};  // ADD
    vecs[11] = '{32'h0020A023, 3'b000, 0, 4'b0100, 1'b0, 5, 1};  // SW
    vecs[12] = '{32'h0000A083, 3'b000, 3, 4'b0100, 1'b1, 8, 4};  // LW, 3 wait cycles

    // Reset values and one-cycle BOOT
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pcc", {28'b0, pc_control}, 32'h8);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_reg_we", {31'b0, reg_we}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_retired", retired, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("boot_pcc", {28'b0, pc_control}, 32'h8);
    step();
    chk("fetch_after_boot", {31'b0, imem_req}, 32'd1);
    chk("fetch_pcc", {28'b0, pc_control}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      run_instr(vecs[i].ins, vecs[i].flags, vecs[i].dwait, pcc, we, en_cyc, dreq_n, ok);
      exp_ret = exp_ret + 32'd1;
      chk($sformatf("v%0d_done", i), {31'b0, ok}, 32'd1);
      chk($sformatf("v%0d_pcc", i), {28'b0, pcc}, {28'b0, vecs[i].pcc});
      chk($sformatf("v%0d_reg_we", i), {31'b0, we}, {31'b0, vecs[i].we});
      chk($sformatf("v%0d_en_cycle", i), en_cyc, vecs[i].cyc);
      chk($sformatf("v%0d_dmem_req_cycles", i), dreq_n, vecs[i].dreq);
      chk($sformatf("v%0d_en_single", i), {31'b0, pc_control[PCC_EN]}, 32'd0);
      chk($sformatf("v%0d_back_to_fetch", i), {31'b0, imem_req}, 32'd1);
      chk($sformatf("v%0d_retired", i), retired, exp_ret);
      chk($sformatf("v%0d_ir", i), ir, vecs[i].ins);
    end

    // Full branch truth table: funct3[2:1] picks eq/lt/ltu, funct3[0] inverts, 01x never taken
    for (int f = 0; f < 8; f++) begin
      for (int fl = 0; fl < 8; fl++) begin
        logic [2:0] f3;
        logic [2:0] flg;
        logic       sel;
        logic       texp;
        f3  = f[2:0];
        flg = fl[2:0];
        case (f3[2:1])
          2'b00:   sel = flg[2];
          2'b10:   sel = flg[1];
          2'b11:   sel = flg[0];
          default: sel = 1'b0;
        endcase
        texp = (f3[2:1] == 2'b01) ? 1'b0 : (sel ^ f3[0]);
        run_instr({17'b0, f3, 5'b0, 7'b1100011}, flg, 0, pcc, we, en_cyc, dreq_n, ok);
        exp_ret = exp_ret + 32'd1;
        chk($sformatf("br_f%0d_fl%0d", f, fl), {28'b0, pcc}, {28'b0, 2'b01, texp, 1'b0});
      end
    end
    chk("br_table_retired", retired, exp_ret);

    // Retired counter wrap
    force dut.retired_q = 32'hFFFF_FFFF;
    step();
    release dut.retired_q;
    chk("wrap_preload", retired, 32'hFFFF_FFFF);
    run_instr(32'h00500093, 3'b000, 0, pcc, we, en_cyc, dreq_n, ok);
    exp_ret = 32'h0;
    chk("wrap_retired", retired, 32'h0);

    // ECALL halts with stray acks ignored
    halt_seq(32'h00000073, "ecall");

    // Unrecognised opcode halts
    do_reset();
    exp_ret = 32'h0;
    chk("reset_after_halt", {31'b0, halted}, 32'd0);
    halt_seq(32'h0000007F, "illegal");

    // Reset asserted during a FETCH wait
    do_reset();
    run_instr(32'h00500093, 3'b000, 0, pcc, we, en_cyc, dreq_n, ok);
    chk("midfetch_pre_retired", retired, 32'd1);
    instr = 32'h002081B3;
    repeat (3) step();
    chk("midfetch_waiting", {31'b0, imem_req}, 32'd1);
    chk("midfetch_ir_held", ir, 32'h00500093);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midfetch_rst_pcc", {28'b0, pc_control}, 32'h8);
    chk("midfetch_rst_req", {31'b0, imem_req}, 32'd0);
    chk("midfetch_rst_ir", ir, 32'h0);
    chk("midfetch_rst_retired", retired, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("midfetch_refetch", {31'b0, imem_req}, 32'd1);
    run_instr(32'h00500093, 3'b000, 0, pcc, we, en_cyc, dreq_n, ok);
    chk("midfetch_resume_pcc", {28'b0, pcc}, 32'h4);
    chk("midfetch_resume_retired", retired, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
